// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bus between the UART receiver and its receive FIFO.
// The receiver/consumer side (master) writes bytes with wr_n and pops
// them with rd. The FIFO side (slave) shows the head entry show-ahead.
interface uart_rx_fifo_if;
  logic       wr_n;
  logic [7:0] wr_data;
  logic       wr_parity_err;
  logic       rd;
  logic [7:0] rd_data;
  logic       rd_parity_err;

  modport master (
    output wr_n, wr_data, wr_parity_err, rd,
    input  rd_data, rd_parity_err
  );

  modport slave (
    input  wr_n, wr_data, wr_parity_err, rd,
    output rd_data, rd_parity_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver. Stores {parity_err, data} per byte,
// presents the head entry show-ahead, and keeps registered status flags
// (empty/full/level/thresh_hit) plus a sticky overflow flag.
module uart_rx_fifo #(
  parameter int ADDR_W = 4,
  parameter int THRESH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_rx_fifo_if.slave     bus,
  input  logic              flush,
  input  logic              clear_overflow,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              thresh_hit,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   THRESH_L = (ADDR_W+1)'(THRESH);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic [ADDR_W:0]   level_next;

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  always_comb begin
    push    = ~bus.wr_n & (~full | bus.rd);
    pop     = bus.rd & ~empty;
    ovf_set = ~bus.wr_n & full & ~bus.rd;
  end

  // Next fill level; flags are registered from this so they move on the same edge.
  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else if (push && !pop) begin
      level_next = level + LVL_ONE;
    end else if (pop && !push) begin
      level_next = level - LVL_ONE;
    end
  end

  // Pointers, level counter and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      thresh_hit <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
      level      <= level_next;
      empty      <= (level_next == '0);
      full       <= (level_next == DEPTH_L);
      thresh_hit <= (level_next >= THRESH_L);
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= {bus.wr_parity_err, bus.wr_data};
    end
  end

  // Sticky overflow: a dropped write wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Show-ahead head entry, forced to zero while nothing is stored.
  always_comb begin
    bus.rd_data       = '0;
    bus.rd_parity_err = 1'b0;
    if (!empty) begin
      {bus.rd_parity_err, bus.rd_data} = mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a queue-based reference model of the FIFO contents,
// a scoreboard of expected popped entries filled by the driver, and a separate
// monitor that compares every entry the DUT actually pops.
module tb_uart_rx_fifo;

  localparam int ADDR_W = 4;
  localparam int THRESH = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush = 1'b0;
  logic              clear_overflow = 1'b0;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   level;
  logic              thresh_hit;
  logic              overflow;

  uart_rx_fifo_if bus();

  uart_rx_fifo #(.ADDR_W(ADDR_W), .THRESH(THRESH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .flush          (flush),
    .clear_overflow (clear_overflow),
    .empty          (empty),
    .full           (full),
    .level          (level),
    .thresh_hit     (thresh_hit),
    .overflow       (overflow)
  );

  // Free-running system clock, 10 time units per period.
  always #5 clk = ~clk;

  logic [8:0] model[$];
  logic [8:0] sb[$];
  bit         modelOvf = 1'b0;
  int         assertCount = 0;
  int         failCount = 0;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Compares all status outputs and the show-ahead head against the model.
  task automatic checkOutput();
    int         lvl;
    logic [8:0] head;
    lvl  = model.size();
    head = (lvl > 0) ? model[0] : 9'h000;
    checkValue("level",         32'(level),         32'(lvl));
    checkValue("empty",         32'(empty),         32'(lvl == 0));
    checkValue("full",          32'(full),          32'(lvl == DEPTH));
    checkValue("thresh_hit",    32'(thresh_hit),    32'(lvl >= THRESH));
    checkValue("overflow",      32'(overflow),      32'(modelOvf));
    checkValue("rd_data",       32'(bus.rd_data),   32'(head[7:0]));
    checkValue("rd_parity_err", 32'(bus.rd_parity_err), 32'(head[8]));
  endtask

  // One clock of stimulus: checks the state left by the previous edge,
  // drives the inputs, and advances the reference model.
  task automatic applyStimulus(input bit wr, input logic [7:0] data, input bit perr,
                               input bit rd, input bit fl, input bit clr);
    int sz;
    @(negedge clk);
    checkOutput();
    bus.wr_n          = !wr;
    bus.wr_data       = data;
    bus.wr_parity_err = perr;
    bus.rd            = rd;
    flush             = fl;
    clear_overflow    = clr;
    sz = model.size();
    if (fl) begin
      model.delete();
    end else begin
      if (rd && sz > 0) sb.push_back(model.pop_front());
      if (wr && (sz < DEPTH || rd)) model.push_back({perr, data});
    end
    if (wr && sz == DEPTH && !rd) modelOvf = 1'b1;
    else if (clr)                 modelOvf = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop at once.
  task automatic doReset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    bus.wr_n = 1'b1; bus.rd = 1'b0; flush = 1'b0; clear_overflow = 1'b0;
    #1;
    checkValue("rst_level",    32'(level),             32'd0);
    checkValue("rst_empty",    32'(empty),             32'd1);
    checkValue("rst_full",     32'(full),              32'd0);
    checkValue("rst_thresh",   32'(thresh_hit),        32'd0);
    checkValue("rst_overflow", 32'(overflow),          32'd0);
    checkValue("rst_rd_data",  32'(bus.rd_data),       32'd0);
    checkValue("rst_rd_perr",  32'(bus.rd_parity_err), 32'd0);
    model.delete();
    sb.delete();
    modelOvf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: whenever the DUT performs a real pop, compare against the scoreboard.
  initial begin : monitor
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n === 1'b1 && bus.rd === 1'b1 && empty === 1'b0 && flush === 1'b0) begin
        if (sb.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected_pop: got 0x%0h, expected no pop at time %0t",
                   bus.rd_data, $time);
        end else begin
          exp = sb.pop_front();
          checkValue("pop_data", 32'(bus.rd_data),       32'(exp[7:0]));
          checkValue("pop_perr", 32'(bus.rd_parity_err), 32'(exp[8]));
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios followed by a randomized phase.
  initial begin : stimulus
    bit wr, rd, fl, clr;
    bus.wr_n = 1'b1; bus.wr_data = '0; bus.wr_parity_err = 1'b0; bus.rd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle();

    $display("[TB] basic write/read");
    applyStimulus(1, 8'hA5, 0, 0, 0, 0);
    applyStimulus(1, 8'h3C, 1, 0, 0, 0);
    idle();
    applyStimulus(0, 8'h00, 0, 1, 0, 0);
    applyStimulus(0, 8'h00, 0, 1, 0, 0);
    idle();

    $display("[TB] fill to full and overflow");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'(i), 0, 0, 0, 0);
    applyStimulus(1, 8'hFF, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 8'h00, 0, 1, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 1);

    $display("[TB] simultaneous wr/rd when full");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'($urandom), 1'($urandom), 0, 0, 0);
    applyStimulus(1, 8'h77, 0, 1, 0, 0);
    idle();
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 8'h00, 0, 1, 0, 0);

    $display("[TB] simultaneous wr/rd when empty");
    applyStimulus(1, 8'h55, 0, 1, 0, 0);
    idle();
    applyStimulus(0, 8'h00, 0, 1, 0, 0);
    applyStimulus(0, 8'h00, 0, 1, 0, 0);
    idle();

    $display("[TB] flush and overflow set/clear priority");
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h20 + i), 0, 0, 0, 0);
    applyStimulus(1, 8'h11, 0, 0, 1, 0);
    idle();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'(8'h80 + i), 1'(i), 0, 0, 0);
    applyStimulus(1, 8'hEE, 0, 0, 0, 1);
    idle();
    applyStimulus(0, 8'h00, 0, 0, 1, 0);
    idle();

    $display("[TB] interleaved stream with pointer wrap and mid-stream reset");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 8'(8'h40 + i), 1'(i), (i >= 4), 0, 0);
      if (i == 30) doReset();
    end
    idle();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      wr  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 45);
      fl  = !wr && ($urandom_range(0, 99) < 3);
      clr = ($urandom_range(0, 99) < 5);
      applyStimulus(wr, 8'($urandom), 1'($urandom), rd, fl, clr);
    end
    idle();
    while (model.size() > 0) applyStimulus(0, 8'h00, 0, 1, 0, 0);
    idle();
    idle();

    checkValue("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
